// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 16-bit ALU: buffers commands, issues them one at a time,
// captures each result after a fixed latency and keeps a running accumulator.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_sel,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic [2:0]  res_sel,
  output logic [15:0] acc,
  input  logic        acc_clear,
  output logic        err_sticky,
  input  logic        err_clear,
  output logic        busy
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_FULL  = FIFO_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [3:0]        WAIT_INIT = 4'(ALU_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Entry layout: {use_acc, sel[2:0], a[15:0], b[15:0]}
  logic [35:0]       r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic [1:0]  r_state;
  logic [3:0]  r_wait;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [2:0]  r_alu_sel;
  logic        r_res_valid;
  logic [15:0] r_res_data;
  logic        r_res_err;
  logic [2:0]  r_res_sel;
  logic [15:0] r_acc;
  logic        r_err_sticky;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_sample;
  logic [35:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_push   = cmd_valid && cmd_ready;
  assign w_pop    = !w_empty && ((r_state == S_IDLE) || ((r_state == S_DONE) && res_ready));
  assign w_sample = (r_state == S_EXEC) && (r_wait == 4'd0);
  assign w_head   = r_mem[r_rd_ptr];

  assign cmd_ready  = (r_count != CNT_FULL);
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign res_sel    = r_res_sel;
  assign acc        = r_acc;
  assign err_sticky = r_err_sticky;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_acc, cmd_sel, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  // Issue happens on every pop; the accumulator is read as it stands at that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait       <= 4'd0;
      r_alu_a      <= 16'd0;
      r_alu_b      <= 16'd0;
      r_alu_sel    <= 3'd0;
      r_res_valid  <= 1'b0;
      r_res_data   <= 16'd0;
      r_res_err    <= 1'b0;
      r_res_sel    <= 3'd0;
      r_acc        <= 16'd0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a   <= w_head[35] ? r_acc : w_head[31:16];
        r_alu_b   <= w_head[15:0];
        r_alu_sel <= w_head[34:32];
        r_wait    <= WAIT_INIT;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_wait == 4'd0) begin
            r_res_data  <= alu_out;
            r_res_err   <= alu_err;
            r_res_sel   <= r_alu_sel;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_pop ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (acc_clear)                 r_acc <= 16'd0;
      else if (w_sample && !alu_err) r_acc <= alu_out;

      // A new error outranks a coincident clear.
      if (w_sample && alu_err) r_err_sticky <= 1'b1;
      else if (err_clear)      r_err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: the bench plays the ALU and predicts every
// captured result, error bit, opcode and accumulator value in command order.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_acc;
   logic [2:0]  cmd_sel;
   logic [15:0] cmd_a, cmd_b;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_sel;
   logic        alu_err;
   logic        res_valid, res_ready, res_err;
   logic [15:0] res_data, acc;
   logic [2:0]  res_sel;
   logic        acc_clear, err_sticky, err_clear, busy;

   // second instance built with a longer ALU latency, fed by a hand-driven ALU
   logic        cmdValid3, cmdReady3;
   logic [15:0] aluA3, aluB3, aluOut3, resData3, acc3;
   logic [2:0]  aluSel3, resSel3;
   logic        resValid3, resErr3, errSticky3, busy3;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
      logic [2:0]  sel;
      logic [15:0] acc;
   } resItem_t;

   resItem_t    scoreboard[$];
   logic [15:0] modelAcc;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // reference ALU: {err, result}
   function automatic logic [16:0] aluFn(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      logic [16:0] r;
      sum = {1'b0, a} + {1'b0, b};
      case (sel)
         3'd0:    r = sum;
         3'd1:    r = {(b > a), a - b};
         3'd2:    r = {1'b0, a & b};
         3'd3:    r = {1'b0, a | b};
         3'd4:    r = {1'b0, a ^ b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   always_comb begin
      {alu_err, alu_out} = aluFn(alu_sel, alu_a, alu_b);
   end

   alu_op_sequencer #(.FIFO_DEPTH(4), .ALU_LATENCY(1)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_err(alu_err),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .res_sel(res_sel), .acc(acc), .acc_clear(acc_clear),
      .err_sticky(err_sticky), .err_clear(err_clear), .busy(busy)
   );

   alu_op_sequencer #(.FIFO_DEPTH(4), .ALU_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .cmd_valid(cmdValid3), .cmd_ready(cmdReady3), .cmd_sel(cmd_sel),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .alu_a(aluA3), .alu_b(aluB3), .alu_sel(aluSel3),
      .alu_out(aluOut3), .alu_err(1'b0),
      .res_valid(resValid3), .res_ready(1'b1), .res_data(resData3),
      .res_err(resErr3), .res_sel(resSel3), .acc(acc3), .acc_clear(acc_clear),
      .err_sticky(errSticky3), .err_clear(err_clear), .busy(busy3)
   );

   // single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // drive one command until accepted, then queue its predicted result
   task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b, input logic useAcc);
      logic [16:0] r;
      resItem_t    item;
      bit          accepted;
      accepted  = 0;
      cmd_valid = 1'b1;
      cmd_sel   = sel;
      cmd_a     = a;
      cmd_b     = b;
      cmd_acc   = useAcc;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            accepted = 1;
         end
      end
      #1 cmd_valid = 1'b0;
      if (!accepted) begin
         checkOutput("pushTimeout", 32'd0, 32'd1);
      end else begin
         r         = aluFn(sel, useAcc ? modelAcc : a, b);
         item.data = r[15:0];
         item.err  = r[16];
         item.sel  = sel;
         item.acc  = r[16] ? modelAcc : r[15:0];
         modelAcc  = item.acc;
         scoreboard.push_back(item);
      end
   endtask

   task automatic waitIdle();
      bit idle;
      idle = 0;
      for (int i = 0; i < 500 && !idle; i++) begin
         @(negedge clk);
         idle = !busy && !res_valid && (scoreboard.size() == 0);
      end
      if (!idle) checkOutput("idleTimeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // result monitor: every handshake must match the oldest prediction
   always @(negedge clk) begin
      if (reset && res_valid && res_ready) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpectedResult", 32'd1, 32'd0);
         end else begin
            resItem_t exp;
            exp = scoreboard.pop_front();
            checkOutput("resData", {16'd0, res_data}, {16'd0, exp.data});
            checkOutput("resErr", {31'd0, res_err}, {31'd0, exp.err});
            checkOutput("resSel", {29'd0, res_sel}, {29'd0, exp.sel});
            checkOutput("resAcc", {16'd0, acc}, {16'd0, exp.acc});
         end
      end
   end

   initial begin
      int          lat;
      bit          found;
      bit          sawValid;
      logic [15:0] vals [1:7];

      reset = 1'b0;
      cmd_valid = 1'b0; cmd_sel = 3'd0; cmd_a = 16'd0; cmd_b = 16'd0; cmd_acc = 1'b0;
      res_ready = 1'b1; acc_clear = 1'b0; err_clear = 1'b0;
      cmdValid3 = 1'b0; aluOut3 = 16'd0;
      modelAcc = 16'd0;
      tick(2);
      checkOutput("rstResValid", {31'd0, res_valid}, 32'd0);
      checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd1);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstAcc", {16'd0, acc}, 32'd0);
      checkOutput("rstAluA", {16'd0, alu_a}, 32'd0);
      checkOutput("rstSticky", {31'd0, err_sticky}, 32'd0);
      reset = 1'b1;
      tick(1);

      // basic add plus acceptance-to-valid latency
      applyStimulus(3'd0, 16'd3080, 16'd756, 1'b0);
      lat = 0; found = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         @(negedge clk);
         if (res_valid) begin found = 1; lat = i; end
      end
      checkOutput("latency", lat, 32'd3);
      waitIdle();
      checkOutput("acc3836", {16'd0, acc}, 32'd3836);

      // overflow error, sticky flag and its clear
      applyStimulus(3'd0, 16'hFFFF, 16'd2, 1'b0);
      waitIdle();
      checkOutput("stickySet", {31'd0, err_sticky}, 32'd1);
      checkOutput("accKeptOnErr", {16'd0, acc}, 32'd3836);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      checkOutput("stickyCleared", {31'd0, err_sticky}, 32'd0);

      err_clear = 1'b1;
      applyStimulus(3'd1, 16'd4, 16'd9, 1'b0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (res_valid) found = 1;
      end
      checkOutput("setBeatsClear", {31'd0, err_sticky}, 32'd1);
      @(posedge clk);
      #1 err_clear = 1'b0;
      waitIdle();

      // chained arithmetic through the accumulator
      applyStimulus(3'd0, 16'd10, 16'd5, 1'b0);
      applyStimulus(3'd0, 16'hDEAD, 16'd3, 1'b1);
      waitIdle();
      checkOutput("chainAluA", {16'd0, alu_a}, 32'd15);
      checkOutput("chainAcc", {16'd0, acc}, 32'd18);
      acc_clear = 1'b1;
      tick(1);
      acc_clear = 1'b0;
      modelAcc = 16'd0;
      checkOutput("accCleared", {16'd0, acc}, 32'd0);

      // fill the FIFO behind a stalled result, then drain in order
      res_ready = 1'b0;
      applyStimulus(3'd1, 16'd500, 16'd200, 1'b0);
      applyStimulus(3'd1, 16'd5, 16'd9, 1'b0);
      applyStimulus(3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
      applyStimulus(3'd4, 16'($urandom), 16'($urandom), 1'b0);
      applyStimulus(3'd0, 16'd0, 16'd100, 1'b1);
      checkOutput("fullCmdReady", {31'd0, cmd_ready}, 32'd0);
      checkOutput("fullBusy", {31'd0, busy}, 32'd1);
      cmd_valid = 1'b1; cmd_sel = 3'd3; cmd_a = 16'h1234; cmd_b = 16'h4321; cmd_acc = 1'b0;
      tick(3);
      cmd_valid = 1'b0;
      checkOutput("stillFull", {31'd0, cmd_ready}, 32'd0);
      checkOutput("pendingResults", scoreboard.size(), 32'd5);
      res_ready = 1'b1;
      waitIdle();
      checkOutput("drained", scoreboard.size(), 32'd0);

      // reset while a command executes and another waits in the FIFO
      applyStimulus(3'd2, 16'h00FF, 16'h0F0F, 1'b0);
      applyStimulus(3'd3, 16'h0001, 16'h0002, 1'b0);
      checkOutput("preRstAcc", {31'd0, (acc != 16'd0)}, 32'd1);
      reset = 1'b0;
      #1;
      scoreboard.delete();
      modelAcc = 16'd0;
      checkOutput("midRstResValid", {31'd0, res_valid}, 32'd0);
      checkOutput("midRstCmdReady", {31'd0, cmd_ready}, 32'd1);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstAcc", {16'd0, acc}, 32'd0);
      tick(2);
      reset = 1'b1;
      sawValid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid) sawValid = 1;
      end
      checkOutput("noGhostResult", {31'd0, sawValid}, 32'd0);
      tick(1);

      // latency-3 instance: only the value present on the sample cycle counts
      vals[1] = 16'h1111; vals[2] = 16'h2222; vals[3] = 16'h3333; vals[4] = 16'h4444;
      vals[5] = 16'h5555; vals[6] = 16'h6666; vals[7] = 16'h7777;
      cmdValid3 = 1'b1; cmd_sel = 3'd5; cmd_a = 16'h0ABC; cmd_b = 16'd0; cmd_acc = 1'b0;
      tick(1);
      cmdValid3 = 1'b0;
      lat = 0; found = 0;
      for (int k = 1; k <= 7; k++) begin
         aluOut3 = vals[k];
         @(negedge clk);
         if (resValid3 && !found) begin
            found = 1;
            lat = k;
            checkOutput("lat3Data", {16'd0, resData3}, 32'h4444);
            checkOutput("lat3Sel", {29'd0, resSel3}, 32'd5);
            checkOutput("lat3AluA", {16'd0, aluA3}, 32'h0ABC);
         end
         @(posedge clk);
         #1;
      end
      checkOutput("lat3Cycle", lat, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
